// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default address width/reset vector and the sequencing-operation encoding.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W = 16;
    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_VECTOR = 16'h0000;

    typedef enum logic [2:0] {
        SEQ_HOLD,
        SEQ_INC,
        SEQ_JUMP,
        SEQ_CALL,
        SEQ_RET,
        SEQ_TRAP
    } seq_op_t;

endpackage

// File: rtl/return_stack.sv
// Parametrised LIFO of return addresses; combinational top-of-stack, synchronous push/pop.
module return_stack
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_ADDR_W,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [DATA_W-1:0]              din,
    output logic [DATA_W-1:0]              top,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  wr_idx;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = IDX_W'(count - CNT_W'(1));
    assign wr_idx  = IDX_W'(count);
    assign top     = empty ? '0 : mem[top_idx];

    // Occupancy counter; pop wins if both are requested
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end
    end

    // Contents carry no reset; they are only read below count
    always_ff @(posedge clk) begin
        if (!reset && push && !pop && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter with jump/call/return sequencing over a hardware return stack.
// Optional trap-on-stack-fault behaviour enabled by defining PROGRAM_SEQUENCER_TRAP_EN.
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned         ADDR_W       = CPU_ADDR_W,
    parameter int unsigned         STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0]   RESET_VECTOR = ADDR_W'(CPU_RESET_VECTOR),
    parameter logic [ADDR_W-1:0]   TRAP_VECTOR  = ADDR_W'(16'hFFF0)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic                              jump_enable,
    input  logic                              call_enable,
    input  logic                              return_enable,
    input  logic [ADDR_W-1:0]                 jump_address,
    output logic [ADDR_W-1:0]                 counter_reg,
    output logic [$clog2(STACK_DEPTH+1)-1:0]  stack_count,
    output logic                              stack_overflow,
`ifdef PROGRAM_SEQUENCER_TRAP_EN
    output logic                              stack_underflow,
    output logic                              trap
`else
    output logic                              stack_underflow
`endif
);

    seq_op_t           op;
    logic              push;
    logic              pop;
    logic              overflow_c;
    logic              underflow_c;
    logic              stack_full;
    logic              stack_empty;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] stack_top;

    assign pc_inc = counter_reg + ADDR_W'(1);

    return_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_return_stack (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .din    (pc_inc),
        .top    (stack_top),
        .count  (stack_count),
        .full   (stack_full),
        .empty  (stack_empty)
    );

    // Priority decode: stall > return > call > jump > increment
    always_comb begin
        op          = SEQ_INC;
        push        = 1'b0;
        pop         = 1'b0;
        overflow_c  = 1'b0;
        underflow_c = 1'b0;
        if (stall) begin
            op = SEQ_HOLD;
        end else if (return_enable) begin
            if (stack_empty) begin
                underflow_c = 1'b1;
`ifdef PROGRAM_SEQUENCER_TRAP_EN
                op = SEQ_TRAP;
`else
                op = SEQ_INC;
`endif
            end else begin
                op  = SEQ_RET;
                pop = 1'b1;
            end
        end else if (call_enable) begin
            if (stack_full) begin
                overflow_c = 1'b1;
`ifdef PROGRAM_SEQUENCER_TRAP_EN
                op = SEQ_TRAP;
`else
                op = SEQ_JUMP;
`endif
            end else begin
                op   = SEQ_CALL;
                push = 1'b1;
            end
        end else if (jump_enable) begin
            op = SEQ_JUMP;
        end
    end

    always_comb begin
        pc_next = counter_reg;
        case (op)
            SEQ_HOLD: pc_next = counter_reg;
            SEQ_INC:  pc_next = pc_inc;
            SEQ_JUMP: pc_next = jump_address;
            SEQ_CALL: pc_next = jump_address;
            SEQ_RET:  pc_next = stack_top;
            SEQ_TRAP: pc_next = TRAP_VECTOR;
            default:  pc_next = counter_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_reg     <= RESET_VECTOR;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            counter_reg     <= pc_next;
            stack_overflow  <= overflow_c;
            stack_underflow <= underflow_c;
        end
    end

`ifdef PROGRAM_SEQUENCER_TRAP_EN
    // Sticky until reset; stall cannot produce SEQ_TRAP so it holds naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            trap <= 1'b0;
        end else if (op == SEQ_TRAP) begin
            trap <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with an expected-result scoreboard queue.
module tb_program_sequencer;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam logic [15:0] TRAP_V = 16'hFFF0;
`ifdef PROGRAM_SEQUENCER_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    typedef struct {
        string              tag;
        logic [ADDR_W-1:0]  pc;
        logic [CNT_W-1:0]   cnt;
        logic               ovf;
        logic               unf;
        logic               trp;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              jump_enable;
    logic              call_enable;
    logic              return_enable;
    logic [ADDR_W-1:0] jump_address;
    logic [ADDR_W-1:0] counter_reg;
    logic [CNT_W-1:0]  stack_count;
    logic              stack_overflow;
    logic              stack_underflow;
    logic              trap_obs;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    program_sequencer #(
        .ADDR_W       (ADDR_W),
        .STACK_DEPTH  (DEPTH),
        .RESET_VECTOR (16'h0000),
        .TRAP_VECTOR  (TRAP_V)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .jump_enable     (jump_enable),
        .call_enable     (call_enable),
        .return_enable   (return_enable),
        .jump_address    (jump_address),
        .counter_reg     (counter_reg),
        .stack_count     (stack_count),
        .stack_overflow  (stack_overflow),
`ifdef PROGRAM_SEQUENCER_TRAP_EN
        .stack_underflow (stack_underflow),
        .trap            (trap_obs)
`else
        .stack_underflow (stack_underflow)
`endif
    );

`ifndef PROGRAM_SEQUENCER_TRAP_EN
    assign trap_obs = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, queue the expectation, then compare after the edge
    task automatic step(input string tag, input logic rst, input logic stl,
                        input logic je, input logic ce, input logic re,
                        input logic [15:0] ja, input logic [15:0] epc,
                        input logic [CNT_W-1:0] ecnt, input logic eovf,
                        input logic eunf, input logic etrp);
        exp_t e;
        reset         = rst;
        stall         = stl;
        jump_enable   = je;
        call_enable   = ce;
        return_enable = re;
        jump_address  = ja;
        e.tag = tag; e.pc = epc; e.cnt = ecnt; e.ovf = eovf; e.unf = eunf; e.trp = etrp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, ".pc"},  32'(counter_reg),     32'(e.pc));
            check({e.tag, ".cnt"}, 32'(stack_count),     32'(e.cnt));
            check({e.tag, ".ovf"}, 32'(stack_overflow),  32'(e.ovf));
            check({e.tag, ".unf"}, 32'(stack_underflow), 32'(e.unf));
            if (TRAP_ON) check({e.tag, ".trap"}, 32'(trap_obs), 32'(e.trp));
        end
    endtask

    initial begin
        logic [15:0] ovf_pc;
        logic [15:0] unf_pc;
        ovf_pc = TRAP_ON ? TRAP_V : 16'h0300;
        unf_pc = TRAP_ON ? TRAP_V : 16'h0021;

        //         tag          rst  stl  je   ce   re   ja        pc        cnt  ovf  unf  trap
        step("reset",     1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'd0,1'b0,1'b0,1'b0);
        step("inc1",      1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0001,2'd0,1'b0,1'b0,1'b0);
        step("inc2",      1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0002,2'd0,1'b0,1'b0,1'b0);
        step("inc3",      1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0003,2'd0,1'b0,1'b0,1'b0);
        step("inc4",      1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0004,2'd0,1'b0,1'b0,1'b0);

        step("jmp_fffe",  1'b0,1'b0,1'b1,1'b0,1'b0,16'hFFFE,16'hFFFE,2'd0,1'b0,1'b0,1'b0);
        step("inc_ffff",  1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'hFFFF,2'd0,1'b0,1'b0,1'b0);
        step("wrap_0",    1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'd0,1'b0,1'b0,1'b0);

        step("jmp_0010",  1'b0,1'b0,1'b1,1'b0,1'b0,16'h0010,16'h0010,2'd0,1'b0,1'b0,1'b0);
        step("call_0100", 1'b0,1'b0,1'b0,1'b1,1'b0,16'h0100,16'h0100,2'd1,1'b0,1'b0,1'b0);
        step("call_0200", 1'b0,1'b0,1'b0,1'b1,1'b0,16'h0200,16'h0200,2'd2,1'b0,1'b0,1'b0);
        step("ret_0101",  1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0101,2'd1,1'b0,1'b0,1'b0);
        step("ret_0011",  1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0011,2'd0,1'b0,1'b0,1'b0);

        // Fill the depth-2 stack, then overflow
        step("fill_1",    1'b0,1'b0,1'b0,1'b1,1'b0,16'h0100,16'h0100,2'd1,1'b0,1'b0,1'b0);
        step("fill_2",    1'b0,1'b0,1'b0,1'b1,1'b0,16'h0200,16'h0200,2'd2,1'b0,1'b0,1'b0);
        step("ovf_call",  1'b0,1'b0,1'b0,1'b1,1'b0,16'h0300,ovf_pc,  2'd2,1'b1,1'b0,TRAP_ON);
        step("ovf_after", 1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,ovf_pc + 16'd1,2'd2,1'b0,1'b0,TRAP_ON);
        step("ovf_reset", 1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'd0,1'b0,1'b0,1'b0);

        // Underflow, then trap stays sticky through further sequencing
        step("jmp_0020",  1'b0,1'b0,1'b1,1'b0,1'b0,16'h0020,16'h0020,2'd0,1'b0,1'b0,1'b0);
        step("unf_ret",   1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,unf_pc,  2'd0,1'b0,1'b1,TRAP_ON);
        step("unf_after", 1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,unf_pc + 16'd1,2'd0,1'b0,1'b0,TRAP_ON);
        step("jmp_0030",  1'b0,1'b0,1'b1,1'b0,1'b0,16'h0030,16'h0030,2'd0,1'b0,1'b0,TRAP_ON);
        step("call_0040", 1'b0,1'b0,1'b0,1'b1,1'b0,16'h0040,16'h0040,2'd1,1'b0,1'b0,TRAP_ON);

        // Stall with call+return, release, then reset
        step("stall_a",   1'b0,1'b1,1'b0,1'b1,1'b1,16'h0500,16'h0040,2'd1,1'b0,1'b0,TRAP_ON);
        step("stall_b",   1'b0,1'b1,1'b0,1'b1,1'b1,16'h0500,16'h0040,2'd1,1'b0,1'b0,TRAP_ON);
        step("cr_ret",    1'b0,1'b0,1'b0,1'b1,1'b1,16'h0500,16'h0031,2'd0,1'b0,1'b0,TRAP_ON);
        step("rst_win",   1'b1,1'b1,1'b1,1'b1,1'b1,16'h0500,16'h0000,2'd0,1'b0,1'b0,1'b0);
        step("post_rst",  1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0001,2'd0,1'b0,1'b0,1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
